uart_tx_frame_engine: RTL and testbench
=======================================

// Module: uart_tx_frame_engine
// PURPOSE
//  Complete UART transmitter: FSM, serializer, parity generator and baud-tick counter in one block.
//  Parametrised in data width; parity, parity type, stop-bit count and bit period are runtime controls.
//  Supports back-to-back frames with no idle gap and issues a per-frame done pulse.
//  Sits between the system-side byte source and the TX pad.
// PARAMETERS
//  DATA_WIDTH   8    data bits per frame, valid range 5..9, sent LSB first
//  PRESC_WIDTH  16   width of the Prescale input (clocks per bit)
// PORTS
//  CLK            in   1            system clock
//  RST            in   1            synchronous reset, active-high
//  P_DATA         in   DATA_WIDTH   parallel data to send
//  Data_Valid     in   1            P_DATA/config valid; acts as request
//  parity_enable  in   1            1 = insert parity bit after data
//  parity_type    in   1            0 = even, 1 = odd
//  stop2          in   1            1 = two stop bits, 0 = one
//  Prescale       in   PRESC_WIDTH  clocks per bit; 0 is treated as 1
//  TX_OUT         out  1            serial line, idle high, registered
//  busy           out  1            frame in progress, registered
//  done           out  1            one-cycle pulse after the final stop bit
// BEHAVIOUR
//  Reset (RST=1 at CLK edge): TX_OUT=1, busy=0, done=0, state=IDLE, all counters 0.
//    Reset takes effect mid-frame too. The frame is discarded and the line is high on the next cycle.
//  States: IDLE -> START -> DATA -> [PARITY if pe] -> STOP -> IDLE, or -> START on back-to-back.
//  Accept point: Data_Valid=1 while in IDLE, or in the last clock of the final stop bit.
//    Data_Valid is ignored at every other time.
//  On accept, the block latches P_DATA, parity_enable, parity_type, stop2 and Prescale (P).
//    Input changes during a frame have no effect on it.
//  Latency: TX_OUT=0 (start bit) and busy=1 in the cycle after accept.
//  Each bit is held exactly P clocks (Pe = max(P,1)). Prescale counter runs 0..Pe-1.
//    The bit advances when the counter reaches Pe-1.
//  DATA: bit index 0..DATA_WIDTH-1, LSB first. Leave DATA after index DATA_WIDTH-1 completes.
//  Parity bit: even = ^data, odd = ~^data, computed from the latched data.
//  STOP: TX_OUT=1 for Pe clocks, or 2*Pe clocks when stop2 is set.
//  Frame length = Pe*(1 + DATA_WIDTH + pe + 1 + stop2) clocks. No idle clocks between back-to-back frames.
//  busy = 1 exactly for the clocks TX_OUT carries a frame. It stays 1 across back-to-back frames.
//  done = 1 for the single cycle after the last stop-bit clock.
//    This holds whether the next state is IDLE or START.
//  TX_OUT is driven from a flop. The combinational mux output is not visible at the port.
//  Illegal or unused state encodings recover to IDLE with TX_OUT=1.
// TESTING
//  T1 8'hA5, P=4, pe=0, stop2=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,1, each bit 4 clk.
//     busy high 40 clk; done pulse on clk 41.
//  T2 8'h07, P=2, pe=1, type=even -> parity bit 1. Same data with type=odd -> parity bit 0.
//     Frame is 22 clk in both cases.
//  T3 Data_Valid held high, data 8'h55 then 8'h3C, P=1 -> the second start bit immediately follows the stop bit.
//     busy never drops; two done pulses 10 clk apart.
//  T4 stop2=1, P=1, pe=1 -> frame is 12 clk. Changing Prescale/P_DATA mid-frame does not alter TX_OUT.
//  T5 RST=1 during the 3rd data bit -> next cycle TX_OUT=1, busy=0, done=0.
//     A new request after reset sends a clean frame.
//  T6 Prescale=0 behaves identically to Prescale=1. Rebuild with DATA_WIDTH=5 and repeat T1 using 5'h15.

Source files
------------

// File: rtl/uart_tx_frame_engine.sv
// UART transmitter: start bit, LSB-first data, optional parity, one or two stop bits,
// with a per-bit prescaler and gap-free back-to-back frames.
module uart_tx_frame_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   parity_enable,
  input  logic                   parity_type,
  input  logic                   stop2,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             fsm_state
);

  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]             state, state_next;
  logic [PRESC_WIDTH-1:0] presc_cnt, presc_next, period_q;
  logic [BW-1:0]          bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   par_en_q, par_type_q, stop2_q;
  logic                   tick, last_data, last_stop, accept;
  logic                   tx_next, busy_next, par_bit;

  // Handshake: Data_Valid is a request with no ready; it is taken only in IDLE or in
  // the last clock of the final stop bit, and the source watches busy/done to pace itself.
  assign tick      = (presc_cnt == period_q - 1'b1);
  assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign last_stop = (state == STOP) && tick && (bit_cnt == {{(BW-1){1'b0}}, stop2_q});
  assign accept    = Data_Valid && ((state == IDLE) || last_stop);
  assign par_bit   = par_type_q ? ~^data_q : ^data_q;
  assign fsm_state = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      presc_cnt  <= '0;
      bit_cnt    <= '0;
      period_q   <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state     <= state_next;
      presc_cnt <= presc_next;
      bit_cnt   <= bit_next;
      TX_OUT    <= tx_next;
      busy      <= busy_next;
      done      <= last_stop;
      if (accept) begin
        data_q     <= P_DATA;
        par_en_q   <= parity_enable;
        par_type_q <= parity_type;
        stop2_q    <= stop2;
        period_q   <= (Prescale == '0) ? PRESC_WIDTH'(1) : Prescale;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && last_data) state_next = par_en_q ? PARITY : STOP;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (last_stop) state_next = accept ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters and the line value are computed for the state being entered, so the
  // registered TX_OUT lines up with the state register.
  always_comb begin
    presc_next = presc_cnt + 1'b1;
    bit_next   = bit_cnt;
    tx_next    = 1'b1;
    busy_next  = (state_next != IDLE);
    if (state == IDLE || state > STOP || tick) presc_next = '0;
    case (state)
      DATA:    if (tick) bit_next = last_data ? '0 : bit_cnt + 1'b1;
      STOP:    if (tick) bit_next = last_stop ? '0 : bit_cnt + 1'b1;
      START, PARITY: bit_next = '0;
      default: bit_next = '0;
    endcase
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[bit_next];
      PARITY:  tx_next = par_bit;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Bench for uart_tx_frame_engine: directed and random frame sequences compared cycle by
// cycle against a waveform model built from bit lists.
module tb_uart_tx_frame_engine;

  localparam int DW = 8;
  localparam int PW = 16;

  logic          CLK, RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid, parity_enable, parity_type, stop2;
  logic [PW-1:0] Prescale;
  logic          TX_OUT, busy, done;
  logic [2:0]    fsm_state;

  uart_tx_frame_engine #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .parity_enable(parity_enable), .parity_type(parity_type), .stop2(stop2),
    .Prescale(Prescale), .TX_OUT(TX_OUT), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // scoreboard: each entry is {TX_OUT, busy, done} for one clock
  logic [2:0]    exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  bit            pend_done;

  logic [DW-1:0] cfg_data[8];
  bit            cfg_pe[8], cfg_pt[8], cfg_s2[8];
  int            cfg_p[8];
  int            frame_len[8];

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed {tx,busy,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    logic [2:0] e;
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed=%b expected=<empty model queue>", tag, {TX_OUT, busy, done});
    end else begin
      e = exp_q.pop_front();
      chk(tag, {TX_OUT, busy, done}, e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cfg(input int k, input logic [DW-1:0] d, input bit pe, input bit pt,
                         input bit s2, input int p);
    cfg_data[k] = d;
    cfg_pe[k]   = pe;
    cfg_pt[k]   = pt;
    cfg_s2[k]   = s2;
    cfg_p[k]    = p;
  endtask

  task automatic drive_cfg(input int k);
    P_DATA        = cfg_data[k];
    parity_enable = cfg_pe[k];
    parity_type   = cfg_pt[k];
    stop2         = cfg_s2[k];
    Prescale      = cfg_p[k][PW-1:0];
  endtask

  task automatic scramble_inputs();
    P_DATA        = DW'($urandom);
    parity_enable = 1'($urandom);
    parity_type   = 1'($urandom);
    stop2         = 1'($urandom);
    Prescale      = PW'($urandom_range(0, 7));
  endtask

  // reference model: list the line bits, then stretch each one to Pe clocks
  function automatic void push_frame(input int k);
    bit b[$];
    int pe_n, ones;
    pe_n = (cfg_p[k] < 1) ? 1 : cfg_p[k];
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      b.push_back(cfg_data[k][i]);
      if (cfg_data[k][i]) ones++;
    end
    if (cfg_pe[k]) b.push_back(cfg_pt[k] ? ((ones % 2) == 0) : ((ones % 2) == 1));
    b.push_back(1'b1);
    if (cfg_s2[k]) b.push_back(1'b1);
    frame_len[k] = b.size() * pe_n;
    foreach (b[i]) begin
      for (int r = 0; r < pe_n; r++) begin
        exp_q.push_back({b[i], 1'b1, pend_done});
        pend_done = 1'b0;
      end
    end
    pend_done = 1'b1;
  endfunction

  // Sends configs 0..n-1 back to back (Data_Valid held high), next config driven mid-frame.
  task automatic run_seq(input int n, input bit noise, input string tag);
    exp_q.delete();
    pend_done = 1'b0;
    for (int k = 0; k < n; k++) push_frame(k);
    exp_q.push_back({1'b1, 1'b0, pend_done});
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    drive_cfg(0);
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    for (int k = 0; k < n; k++) begin
      if (k + 1 < n) drive_cfg(k + 1);
      else begin
        Data_Valid = 1'b0;
        if (noise) scramble_inputs();
      end
      for (int c = 0; c < frame_len[k]; c++) check_cycle(tag);
    end
    repeat (3) check_cycle(tag);
  endtask

  initial begin
    logic [DW-1:0] t1_data;
    t1_data = (DW == 8) ? DW'(8'hA5) : DW'(5'h15);
    RST = 1'b1;
    Data_Valid = 1'b0;
    P_DATA = '0; parity_enable = 1'b0; parity_type = 1'b0; stop2 = 1'b0; Prescale = '0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("reset", {TX_OUT, busy, done}, 3'b100);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    check_cycle("idle_after_reset");
    check_cycle("idle_after_reset");

    // T1 basic frame
    set_cfg(0, t1_data, 0, 0, 0, 4);
    run_seq(1, 1, "t1_basic");

    // T2 parity even / odd
    set_cfg(0, DW'(8'h07), 1, 0, 0, 2);
    run_seq(1, 1, "t2_even");
    set_cfg(0, DW'(8'h07), 1, 1, 0, 2);
    run_seq(1, 1, "t2_odd");

    // T3 back-to-back, P=1
    set_cfg(0, DW'(8'h55), 0, 0, 0, 1);
    set_cfg(1, DW'(8'h3C), 0, 0, 0, 1);
    run_seq(2, 0, "t3_b2b");

    // T4 two stop bits with parity, config changing under the frame
    set_cfg(0, DW'($urandom), 1, 0, 1, 1);
    set_cfg(1, DW'($urandom), 0, 1, 0, 3);
    run_seq(2, 1, "t4_stop2");

    // T5 reset during the third data bit
    set_cfg(0, DW'(8'hFF), 0, 0, 0, 3);
    drive_cfg(0);
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    repeat (3) exp_q.push_back(3'b100);
    repeat (3) check_cycle("t5_mid_reset");
    set_cfg(0, DW'(8'h96), 1, 1, 1, 2);
    run_seq(1, 0, "t5_clean_frame");

    // T6 Prescale=0 acts as 1
    set_cfg(0, DW'(8'hC3), 1, 0, 0, 0);
    set_cfg(1, DW'(8'h5A), 0, 0, 1, 0);
    run_seq(2, 1, "t6_presc0");

    // randomized sequences
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        set_cfg(k, DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 4));
      run_seq(n, 1, "random");
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
